// File: rtl/voice_mixer_pkg.sv
// Shared definitions for the voice mixer: default sample width, the
// per-voice state encoding driven by the voice pipelines, and the mixer
// FSM state encoding.
package voice_mixer_pkg;

  localparam int MIX_DATA_W = 16;

  // Voice pipeline state as seen on i_state (2 bits per voice)
  typedef enum logic [1:0] {
    VS_IDLE = 2'b00,
    VS_BSY  = 2'b01,
    VS_RDY  = 2'b10
  } voice_state_t;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'b00,
    ST_SCAN  = 2'b01,
    ST_SCALE = 2'b10,
    ST_OUT   = 2'b11
  } mix_state_t;

endpackage

// File: rtl/voice_mixer_sample_tick.sv
// Sample-rate tick generator. Counts 0..SAMPLE_DIV-1 and wraps; tick is
// high for the single cycle in which the count sits at SAMPLE_DIV-1.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-low reset (count cleared to 0)
//   tick  out  one-cycle pulse per sample period
module voice_mixer_sample_tick #(
  parameter int SAMPLE_DIV = 1042
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// Voice mixer. Once per sample tick, sums the samples of every RDY voice
// (one voice per cycle), arithmetic-shifts the sum by GAIN_SHIFT, limits it
// to DATA_W bits and offers it downstream over valid/ready. Reports the
// number of RDY voices in the last mix and a sticky overrun flag set when a
// tick arrives while the previous mix is still in flight or unaccepted.
// Build option: define MIXER_SATURATE_EN to clamp the scaled value to the
// signed DATA_W range; otherwise the scaled value wraps to its low bits.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   i_state    in   per-voice state, voice v at [2v+1:2v]
//   i_signal   in   per-voice signed sample, voice v at [DATA_W*v +: DATA_W]
//   i_ready    in   downstream accepts o_sample this cycle
//   o_sample   out  mixed signed sample
//   o_valid    out  o_sample valid
//   o_active   out  RDY voice count of the last mix
//   o_overrun  out  sticky dropped-tick flag
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_WAIT  | idle until the next sample tick
// ST_SCAN  | accumulate one voice per cycle, NUM_VOICES cycles
// ST_SCALE | shift and limit the sum, load output registers
// ST_OUT   | hold sample until accepted by i_ready
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int DATA_W     = MIX_DATA_W,
  parameter int SAMPLE_DIV = 1042,
  parameter int GAIN_SHIFT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2*NUM_VOICES-1:0]       i_state,
  input  logic [DATA_W*NUM_VOICES-1:0]  i_signal,
  input  logic                          i_ready,
  output logic [DATA_W-1:0]             o_sample,
  output logic                          o_valid,
  output logic [$clog2(NUM_VOICES):0]   o_active,
  output logic                          o_overrun
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int CNT_W = IDX_W + 1;
  // Sum of NUM_VOICES full-scale samples fits with IDX_W guard bits.
  localparam int ACC_W = DATA_W + IDX_W;

  logic tick;

  voice_mixer_sample_tick #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  logic        [1:0]        v_state [NUM_VOICES];
  logic signed [DATA_W-1:0] v_sig   [NUM_VOICES];

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_unpack
    assign v_state[v] = i_state[2*v +: 2];
    assign v_sig[v]   = i_signal[DATA_W*v +: DATA_W];
  end

  mix_state_t               state, state_nxt;
  logic signed [ACC_W-1:0]  acc, acc_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [IDX_W-1:0]         idx, idx_nxt;
  logic [DATA_W-1:0]        sample_nxt;
  logic                     valid_nxt;
  logic [CNT_W-1:0]         active_nxt;
  logic                     overrun_nxt;
  logic [DATA_W-1:0]        limited;

`ifdef MIXER_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(IDX_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(IDX_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] scaled;
  assign scaled = acc >>> GAIN_SHIFT;

  always_comb begin
    limited = scaled[DATA_W-1:0];
    if (scaled > SAT_MAX) begin
      limited = SAT_MAX[DATA_W-1:0];
    end else if (scaled < SAT_MIN) begin
      limited = SAT_MIN[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    limited = DATA_W'(acc >>> GAIN_SHIFT);
  end
`endif

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    sample_nxt  = o_sample;
    valid_nxt   = o_valid;
    active_nxt  = o_active;
    overrun_nxt = o_overrun;

    case (state)
      ST_WAIT: begin
        if (tick) begin
          state_nxt = ST_SCAN;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      ST_SCAN: begin
        if (v_state[idx] == VS_RDY) begin
          acc_nxt = acc + ACC_W'(v_sig[idx]);
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (idx == IDX_W'(NUM_VOICES - 1)) begin
          state_nxt = ST_SCALE;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      ST_SCALE: begin
        sample_nxt = limited;
        active_nxt = cnt;
        valid_nxt  = 1'b1;
        state_nxt  = ST_OUT;
      end
      ST_OUT: begin
        if (i_ready && o_valid) begin
          valid_nxt = 1'b0;
          state_nxt = ST_WAIT;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase

    // Any tick outside WAIT is lost; the mix in progress is left untouched.
    if (tick && (state != ST_WAIT)) begin
      overrun_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_WAIT;
      acc       <= '0;
      cnt       <= '0;
      idx       <= '0;
      o_sample  <= '0;
      o_valid   <= 1'b0;
      o_active  <= '0;
      o_overrun <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      o_sample  <= sample_nxt;
      o_valid   <= valid_nxt;
      o_active  <= active_nxt;
      o_overrun <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
module tb_voice_mixer;

  localparam int NV = 4;
  localparam int DW = 16;
  localparam int SD = 16;

  logic              clk;
  logic              rst;
  logic [2*NV-1:0]   i_state;
  logic [DW*NV-1:0]  i_signal;
  logic              i_ready;

  logic [DW-1:0]     o_sample,  o_sample_g0;
  logic              o_valid,   o_valid_g0;
  logic [2:0]        o_active,  o_active_g0;
  logic              o_overrun, o_overrun_g0;

  voice_mixer #(.NUM_VOICES(NV), .DATA_W(DW), .SAMPLE_DIV(SD), .GAIN_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .i_state(i_state), .i_signal(i_signal), .i_ready(i_ready),
    .o_sample(o_sample), .o_valid(o_valid), .o_active(o_active), .o_overrun(o_overrun)
  );

  voice_mixer #(.NUM_VOICES(NV), .DATA_W(DW), .SAMPLE_DIV(SD), .GAIN_SHIFT(0)) dut_g0 (
    .clk(clk), .rst(rst), .i_state(i_state), .i_signal(i_signal), .i_ready(i_ready),
    .o_sample(o_sample_g0), .o_valid(o_valid_g0), .o_active(o_active_g0), .o_overrun(o_overrun_g0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  st;
    logic [63:0] sig;
    int          exp_s;
    int          exp_a;
    int          exp_g0;
  } vec_t;

  vec_t vecs [7];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    logic [15:0] sa, sb, sc, sd;
    sa = a[15:0]; sb = b[15:0]; sc = c[15:0]; sd = d[15:0];
    return {sd, sc, sb, sa};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (o_valid) ok = 1'b1;
    end
  endtask

  task automatic apply(input int k);
    i_state  = vecs[k].st;
    i_signal = vecs[k].sig;
  endtask

  int n;
  bit ok;

  initial begin
    vecs[0] = '{8'hAA, pack4(1000, 2000, -500, 100),         650,    4, 2600};
    vecs[1] = '{8'h26, pack4(8000, 30000, -8000, 5),         0,      2, 0};
`ifdef MIXER_SATURATE_EN
    vecs[2] = '{8'hAA, pack4(32767, 32767, 32767, 32767),    32767,  4, 32767};
    vecs[3] = '{8'hAA, pack4(-32768, -32768, -32768, -32768), -32768, 4, -32768};
`else
    vecs[2] = '{8'hAA, pack4(32767, 32767, 32767, 32767),    32767,  4, -4};
    vecs[3] = '{8'hAA, pack4(-32768, -32768, -32768, -32768), -32768, 4, 0};
`endif
    vecs[4] = '{8'h00, pack4(111, 222, 333, 444),            0,      0, 0};
    vecs[5] = '{8'h56, pack4(-3, 900, 900, 900),             -1,     1, -3};
    vecs[6] = '{8'h6E, pack4(400, 1234, 4, 77),              101,    2, 404};

    rst = 1'b1; i_ready = 1'b1; i_state = '0; i_signal = '0;
    #3 rst = 1'b0;
    #1;
    chk("rst_sample",  int'($signed(o_sample)), 0);
    chk("rst_valid",   int'(o_valid), 0);
    chk("rst_active",  int'(o_active), 0);
    chk("rst_overrun", int'(o_overrun), 0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b1;

    // Table: i_ready held high, one mix per tick
    for (int k = 0; k < 7; k++) begin
      apply(k);
      wait_valid(40, n, ok);
      chk("valid_seen", int'(ok), 1);
      if (k == 0) chk("latency_first", n, 21);
      chk("sample",  int'($signed(o_sample)), vecs[k].exp_s);
      chk("active",  int'(o_active), vecs[k].exp_a);
      chk("g0_valid", int'(o_valid_g0), 1);
      chk("g0_sample", int'($signed(o_sample_g0)), vecs[k].exp_g0);
      chk("overrun_clear", int'(o_overrun), 0);
      @(posedge clk); #1;
      chk("valid_one_cycle", int'(o_valid), 0);
    end

    // Backpressure across a tick: sample held, overrun set, inputs ignored
    i_ready = 1'b0;
    apply(0);
    wait_valid(40, n, ok);
    chk("bp_valid_seen", int'(ok), 1);
    chk("bp_sample", int'($signed(o_sample)), 650);
    apply(2);
    repeat (20) @(posedge clk);
    #1;
    chk("bp_hold_valid",   int'(o_valid), 1);
    chk("bp_hold_sample",  int'($signed(o_sample)), 650);
    chk("bp_hold_g0",      int'($signed(o_sample_g0)), 2600);
    chk("bp_overrun",      int'(o_overrun), 1);
    i_ready = 1'b1;
    apply(6);
    @(posedge clk); #1;
    chk("bp_accepted",     int'(o_valid), 0);
    chk("bp_keep_sample",  int'($signed(o_sample)), 650);
    chk("bp_keep_active",  int'(o_active), 4);
    wait_valid(40, n, ok);
    chk("bp_next_seen",    int'(ok), 1);
    chk("bp_next_latency", n, 11);
    chk("bp_next_sample",  int'($signed(o_sample)), 101);
    chk("bp_next_active",  int'(o_active), 2);
    chk("bp_overrun_sticky", int'(o_overrun), 1);

    // Asynchronous reset while scanning the following mix
    repeat (12) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_sample",  int'($signed(o_sample)), 0);
    chk("mid_rst_valid",   int'(o_valid), 0);
    chk("mid_rst_active",  int'(o_active), 0);
    chk("mid_rst_overrun", int'(o_overrun), 0);
    @(posedge clk); @(posedge clk); #2 rst = 1'b1;
    apply(0);
    wait_valid(40, n, ok);
    chk("post_rst_seen",    int'(ok), 1);
    chk("post_rst_latency", n, 21);
    chk("post_rst_sample",  int'($signed(o_sample)), 650);
    chk("post_rst_active",  int'(o_active), 4);

    // Tick coincident with acceptance in OUT
    @(posedge clk); #1;
    i_ready = 1'b0;
    apply(5);
    wait_valid(40, n, ok);
    chk("coin_seen",   int'(ok), 1);
    chk("coin_lat",    n, 15);
    chk("coin_sample", int'($signed(o_sample)), -1);
    repeat (10) @(posedge clk);
    #1;
    chk("coin_pre_valid",   int'(o_valid), 1);
    chk("coin_pre_overrun", int'(o_overrun), 0);
    i_ready = 1'b1;
    apply(1);
    @(posedge clk); #1;
    i_ready = 1'b0;
    chk("coin_accepted", int'(o_valid), 0);
    chk("coin_overrun",  int'(o_overrun), 1);
    wait_valid(40, n, ok);
    chk("coin_next_seen",    int'(ok), 1);
    chk("coin_next_latency", n, 21);
    chk("coin_next_sample",  int'($signed(o_sample)), 0);
    chk("coin_next_active",  int'(o_active), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
